// File: rtl/lvds_71tx_framer.sv
// Pixel-to-lane framer for the 7:1 LVDS serializer: pixel FIFO, RGB-to-lane bit mapping,
// clock-lane pattern and a link-training phase after reset or on request.
module lvds_71tx_framer #(
   parameter int         NUM_LINKS    = 1,
   parameter bit         RGB888       = 1'b1,
   parameter bit         MAP_VESA     = 1'b1,
   parameter logic [6:0] CLK_PATTERN  = 7'b1100011,
   parameter logic [6:0] TRAIN_WORD   = 7'b0000111,
   parameter int         TRAIN_CYCLES = 1024,
   parameter int         FIFO_DEPTH   = 8,
   parameter int         START_LEVEL  = 4
) (
   input  logic                            sclk_i,
   input  logic                            reset_i,
   input  logic                            in_valid_i,
   output logic                            in_ready_o,
   input  logic                            in_de_i,
   input  logic                            in_hs_i,
   input  logic                            in_vs_i,
   input  logic [24*NUM_LINKS-1:0]         in_rgb_i,
   input  logic                            train_req_i,
   output logic [7*NUM_LINKS-1:0]          clk_word_o,
   output logic [28*NUM_LINKS-1:0]         lane_word_o,
   output logic                            tx_active_o,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
   output logic [15:0]                     underflow_cnt_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int RW = 24 * NUM_LINKS;
   localparam int DW = RW + 3;
   localparam int CW = (TRAIN_CYCLES > 1) ? $clog2(TRAIN_CYCLES) : 1;

   typedef enum logic [1:0] {S_TRAIN, S_FILL, S_STREAM} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       train_cnt_q, train_cnt_d;
   logic [DW-1:0]       mem_q [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]       level_q;
   logic                hs_last_q, vs_last_q;
   logic [15:0]         underflow_q;
   logic [7*NUM_LINKS-1:0]  clk_word_q;
   logic [28*NUM_LINKS-1:0] lane_word_q, lane_word_d;

   logic                push, pop, flush, ready;
   logic [DW-1:0]       rd_data, beat;
   logic [RW-1:0]       beat_rgb;
   logic                beat_de, beat_hs, beat_vs;
   logic [28*NUM_LINKS-1:0] stream_word, train_word;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge sclk_i) begin
      if (reset_i) begin
         state_q     <= S_TRAIN;
         train_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         train_cnt_q <= train_cnt_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d     = state_q;
      train_cnt_d = '0;
      case (state_q)
         S_TRAIN: begin
            if (train_req_i)
               train_cnt_d = '0;
            else if (train_cnt_q == CW'(TRAIN_CYCLES - 1))
               state_d = S_FILL;
            else
               train_cnt_d = train_cnt_q + CW'(1);
         end
         S_FILL: begin
            if (train_req_i)
               state_d = S_TRAIN;
            else if (level_q >= LW'(START_LEVEL))
               state_d = S_STREAM;
         end
         S_STREAM: begin
            if (train_req_i)
               state_d = S_TRAIN;
         end
         default: state_d = S_TRAIN;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      ready       = !reset_i && (state_q != S_TRAIN) && (level_q != LW'(FIFO_DEPTH));
      pop         = (state_q == S_STREAM) && (level_q != '0);
      lane_word_d = (state_q == S_STREAM) ? stream_word : train_word;
   end

   assign push  = in_valid_i && ready;
   // Beats accepted alongside a training request are dropped with the rest of the queue.
   assign flush = train_req_i;

   always_ff @(posedge sclk_i) begin
      if (reset_i || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         level_q <= level_q + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge sclk_i) begin
      if (push)
         mem_q[wr_ptr_q] <= {in_de_i, in_hs_i, in_vs_i, in_rgb_i};
   end

   assign rd_data = mem_q[rd_ptr_q];

   // A starved cycle sends a blank beat that keeps the last sync levels.
   assign beat     = pop ? rd_data : {1'b0, hs_last_q, vs_last_q, {RW{1'b0}}};
   assign beat_de  = beat[DW-1];
   assign beat_hs  = beat[DW-2];
   assign beat_vs  = beat[DW-3];
   assign beat_rgb = beat[RW-1:0];

   always_ff @(posedge sclk_i) begin
      if (reset_i) begin
         hs_last_q   <= 1'b0;
         vs_last_q   <= 1'b0;
         underflow_q <= '0;
      end else begin
         if (pop) begin
            hs_last_q <= rd_data[DW-2];
            vs_last_q <= rd_data[DW-3];
         end
         if ((state_q == S_STREAM) && (level_q == '0) && (underflow_q != 16'hFFFF))
            underflow_q <= underflow_q + 16'd1;
      end
   end

   for (genvar gi = 0; gi < NUM_LINKS; gi++) begin : g_link
      logic [7:0] r, g, b;
      logic [6:0] l0, l1, l2, l3;
      logic       use_vesa;
      assign r = beat_rgb[24*gi+16 +: 8];
      assign g = beat_rgb[24*gi+8  +: 8];
      assign b = beat_rgb[24*gi    +: 8];
      // RGB666 always takes the top six bits of each colour, whatever MAP_VESA says.
      assign use_vesa = RGB888 && MAP_VESA;
      assign l0 = use_vesa ? {g[0], r[5:0]}   : {g[2], r[7:2]};
      assign l1 = use_vesa ? {b[1:0], g[5:1]} : {b[3:2], g[7:3]};
      assign l2 = use_vesa ? {beat_de, beat_vs, beat_hs, b[5:2]}
                           : {beat_de, beat_vs, beat_hs, b[7:4]};
      assign l3 = !RGB888 ? 7'b0 :
                  (MAP_VESA ? {1'b0, b[7:6], g[7:6], r[7:6]} : {1'b0, b[1:0], g[1:0], r[1:0]});
      assign stream_word[28*gi +: 28] = {l3, l2, l1, l0};
      assign train_word[28*gi +: 28]  = {(RGB888 ? TRAIN_WORD : 7'b0), TRAIN_WORD, TRAIN_WORD, TRAIN_WORD};
   end

   always_ff @(posedge sclk_i) begin
      if (reset_i) begin
         clk_word_q  <= '0;
         lane_word_q <= '0;
      end else begin
         clk_word_q  <= {NUM_LINKS{CLK_PATTERN}};
         lane_word_q <= lane_word_d;
      end
   end

   assign in_ready_o      = ready;
   assign clk_word_o      = clk_word_q;
   assign lane_word_o     = lane_word_q;
   assign tx_active_o     = (state_q == S_STREAM);
   assign fifo_level_o    = level_q;
   assign underflow_cnt_o = underflow_q;

endmodule
